// File: rtl/sram_stream_reader_if.sv
// Bundles the command, SRAM and stream signals of the SRAM stream reader.
// Ports: start/base_addr/len/busy/done (command), CEN/WEN/A/D/Q (SRAM), out_* (stream).
// Modports: master = reader side, slave = environment (command source, SRAM, consumer).
interface sram_stream_reader_if #(
    parameter int AW = 11,
    parameter int DW = 32
);
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   len;
    logic          busy;
    logic          done;
    logic          CEN;
    logic          WEN;
    logic [AW-1:0] A;
    logic [DW-1:0] D;
    logic [DW-1:0] Q;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;

    modport master (
        input  start, base_addr, len, Q, out_ready,
        output busy, done, CEN, WEN, A, D, out_valid, out_data, out_last
    );

    modport slave (
        output start, base_addr, len, Q, out_ready,
        input  busy, done, CEN, WEN, A, D, out_valid, out_data, out_last
    );
endinterface

// File: rtl/sram_stream_reader.sv
// Reads a burst of len words from a 1-cycle-latency SRAM starting at base_addr and streams them out.
// Latency: first word appears on out_valid 2 cycles after the first read issue (3 after start).
// Backpressure: reads are throttled so buffered + in-flight words never exceed 2; out_data holds while stalled.
// Ports: CLK, RESET_N (async, active-low), bus (sram_stream_reader_if.master): command, SRAM and stream signals.
module sram_stream_reader #(
    parameter int AW = 11,
    parameter int DW = 32
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    sram_stream_reader_if.master  bus
);
    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

    localparam logic [AW-1:0] ADDR_ONE = 1;
    localparam logic [AW:0]   LEN_ONE  = 1;

    state_t               state_q;
    logic [AW-1:0]        addr_q;
    logic [AW:0]          remain_q;     // words still to be issued
    logic                 infl_q;       // a read was issued last cycle, Q is valid now
    logic                 infl_last_q;  // that read was the final word of the burst
    logic                 zero_done_q;  // delayed done for a zero-length request
    logic [1:0][DW-1:0]   fifo_dat_q;
    logic [1:0]           fifo_last_q;
    logic                 wr_ptr_q;
    logic                 rd_ptr_q;
    logic [1:0]           count_q;

    logic                 pop;
    logic                 push;
    logic                 issue;
    logic                 last_issue;
    logic                 drain_done;
    logic [2:0]           occupancy;
    logic [1:0]           count_d;

    assign pop        = (count_q != 2'd0) && bus.out_ready;
    assign push       = infl_q;
    // Occupancy counts a slot freed this cycle, so a full-rate stream keeps one read per cycle.
    assign occupancy  = {1'b0, count_q} + {2'b00, infl_q} - {2'b00, pop};
    assign issue      = (state_q == S_READ) && (remain_q != '0) && (occupancy < 3'd2);
    assign last_issue = issue && (remain_q == LEN_ONE);
    assign count_d    = count_q + {1'b0, push} - {1'b0, pop};
    // The last word can only be popped after the final issue, i.e. in DRAIN.
    assign drain_done = (state_q == S_DRAIN) && pop && fifo_last_q[rd_ptr_q];

    assign bus.CEN       = ~issue;
    assign bus.WEN       = 1'b1;
    assign bus.D         = '0;
    assign bus.A         = addr_q;
    assign bus.out_valid = (count_q != 2'd0);
    assign bus.out_data  = fifo_dat_q[rd_ptr_q];
    assign bus.out_last  = (count_q != 2'd0) && fifo_last_q[rd_ptr_q];
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = zero_done_q | drain_done;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remain_q    <= '0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
            zero_done_q <= 1'b0;
            fifo_dat_q  <= '0;
            fifo_last_q <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
        end else begin
            zero_done_q <= 1'b0;
            infl_q      <= issue;
            infl_last_q <= last_issue;
            count_q     <= count_d;

            if (push) begin
                fifo_dat_q[wr_ptr_q]  <= bus.Q;
                fifo_last_q[wr_ptr_q] <= infl_last_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end

            // Address wraps naturally at 2^AW.
            if (issue) begin
                addr_q   <= addr_q + ADDR_ONE;
                remain_q <= remain_q - LEN_ONE;
            end

            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.len != '0) begin
                            state_q  <= S_READ;
                            addr_q   <= bus.base_addr;
                            remain_q <= bus.len;
                        end else begin
                            zero_done_q <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    if (last_issue) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (drain_done) begin
                        state_q <= S_IDLE;
                        addr_q  <= '0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_stream_reader.sv
module tb_sram_stream_reader;
    localparam int AW = 11;
    localparam int DW = 32;
    localparam int NW = 2048;

    logic CLK;
    logic RESET_N;
    logic mon_clr;

    sram_stream_reader_if #(.AW(AW), .DW(DW)) ifc ();

    sram_stream_reader #(.AW(AW), .DW(DW)) dut (
        .CLK    (CLK),
        .RESET_N(RESET_N),
        .bus    (ifc)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // SRAM model: one-cycle read latency.
    logic [DW-1:0] mem [NW];
    always @(posedge CLK) begin
        if (ifc.CEN === 1'b0) ifc.Q <= mem[ifc.A];
    end

    int vectors    = 0;
    int miscompares = 0;

    // Monitor: logs reads, transfers, done pulses and protocol violations at negedge.
    int            rd_q[$];
    logic [DW-1:0] dat_q[$];
    bit            last_q[$];
    int done_cnt, stable_err, bus_err, issued, popped, max_out;
    bit            prev_stall;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    always @(negedge CLK) begin
        if (mon_clr) begin
            rd_q.delete(); dat_q.delete(); last_q.delete();
            done_cnt = 0; stable_err = 0; bus_err = 0;
            issued = 0; popped = 0; max_out = 0; prev_stall = 0;
        end else begin
            if (prev_stall && (ifc.out_valid !== 1'b1 || ifc.out_data !== prev_data ||
                               ifc.out_last !== prev_last)) stable_err++;
            if (ifc.CEN === 1'b0) begin
                rd_q.push_back(int'(ifc.A));
                issued++;
                if (ifc.WEN !== 1'b1 || ifc.D !== '0) bus_err++;
            end
            if (ifc.out_valid === 1'b1 && ifc.out_ready === 1'b1) begin
                dat_q.push_back(ifc.out_data);
                last_q.push_back(ifc.out_last);
                popped++;
            end
            if (issued - popped > max_out) max_out = issued - popped;
            if (ifc.done === 1'b1) done_cnt++;
            prev_stall = (ifc.out_valid === 1'b1) && (ifc.out_ready !== 1'b1);
            prev_data  = ifc.out_data;
            prev_last  = ifc.out_last;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic mon_clear();
        @(posedge CLK); #1 mon_clr = 1'b1;
        @(posedge CLK); #1 mon_clr = 1'b0;
    endtask

    // Starts a burst and waits (bounded) for done. stall selects out_ready pattern 1,0,0,...
    // poke issues a second start mid-burst, which must be ignored.
    task automatic run_burst(input int base, input int ln, input bit stall, input bit poke);
        int cyc;
        mon_clear();
        ifc.out_ready = 1'b1;
        ifc.start = 1'b1; ifc.base_addr = AW'(base); ifc.len = (AW+1)'(ln);
        @(posedge CLK); #1 ifc.start = 1'b0;
        cyc = 0;
        while (done_cnt == 0 && cyc < 5000) begin
            ifc.out_ready = stall ? (cyc % 3 == 0) : 1'b1;
            ifc.start     = poke && (cyc == 2);
            ifc.base_addr = poke ? AW'(100) : AW'(base);
            @(posedge CLK); #1;
            cyc++;
        end
        ifc.start = 1'b0;
        ifc.out_ready = 1'b1;
    endtask

    task automatic check_burst(input string tag, input int base, input int ln);
        int bad_a, bad_d, bad_l, ea;
        bad_a = 0; bad_d = 0; bad_l = 0;
        chk({tag, " read count"}, rd_q.size(), ln);
        chk({tag, " word count"}, dat_q.size(), ln);
        for (int i = 0; i < ln && i < rd_q.size(); i++) begin
            ea = (base + i) % NW;
            if (rd_q[i] != ea) bad_a++;
        end
        for (int i = 0; i < ln && i < dat_q.size(); i++) begin
            ea = (base + i) % NW;
            if (dat_q[i] !== DW'(ea + 100)) bad_d++;
            if (last_q[i] != (i == ln - 1)) bad_l++;
        end
        chk({tag, " address order errors"}, bad_a, 0);
        chk({tag, " data order errors"}, bad_d, 0);
        chk({tag, " out_last placement errors"}, bad_l, 0);
        chk({tag, " done pulses"}, done_cnt, 1);
        chk({tag, " outstanding<=2"}, (max_out <= 2), 1);
        chk({tag, " stall stability errors"}, stable_err, 0);
        chk({tag, " WEN/D errors"}, bus_err, 0);
    endtask

    // Cycle-by-cycle expectations for base=5, len=4, cycles 1..7 after the start cycle.
    int exp_cen  [8] = '{1, 0, 0, 0, 0, 1, 1, 1};
    int exp_val  [8] = '{0, 0, 0, 1, 1, 1, 1, 0};
    int exp_dat  [8] = '{0, 0, 0, 105, 106, 107, 108, 0};
    int exp_last [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
    int exp_done [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
    int exp_busy [8] = '{0, 1, 1, 1, 1, 1, 1, 0};

    initial begin
        int rd_before, cyc;
        for (int i = 0; i < NW; i++) mem[i] = DW'(i + 100);
        RESET_N = 1'b0; mon_clr = 1'b0;
        ifc.start = 1'b0; ifc.base_addr = '0; ifc.len = '0; ifc.out_ready = 1'b1; ifc.Q = '0;

        // Reset state
        @(negedge CLK);
        chk("reset CEN", ifc.CEN, 1);
        chk("reset A", ifc.A, 0);
        chk("reset busy", ifc.busy, 0);
        chk("reset done", ifc.done, 0);
        chk("reset out_valid", ifc.out_valid, 0);
        chk("reset out_last", ifc.out_last, 0);
        chk("reset out_data", ifc.out_data, 0);
        repeat (2) @(posedge CLK);
        #3 RESET_N = 1'b1;

        // Basic burst, checked every cycle
        mon_clear();
        ifc.start = 1'b1; ifc.base_addr = 11'd5; ifc.len = 12'd4;
        @(negedge CLK);
        chk("b5 c0 busy", ifc.busy, 0);
        chk("b5 c0 CEN", ifc.CEN, 1);
        @(posedge CLK); #1 ifc.start = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge CLK);
            chk($sformatf("b5 c%0d CEN", c), ifc.CEN, exp_cen[c]);
            if (c <= 4) chk($sformatf("b5 c%0d A", c), ifc.A, 4 + c);
            chk($sformatf("b5 c%0d out_valid", c), ifc.out_valid, exp_val[c]);
            if (exp_val[c] != 0) chk($sformatf("b5 c%0d out_data", c), ifc.out_data, exp_dat[c]);
            chk($sformatf("b5 c%0d out_last", c), ifc.out_last, exp_last[c]);
            chk($sformatf("b5 c%0d done", c), ifc.done, exp_done[c]);
            chk($sformatf("b5 c%0d busy", c), ifc.busy, exp_busy[c]);
        end
        chk("b5 idle A", ifc.A, 0);
        check_burst("b5", 5, 4);

        // Address wrap, plus an ignored start while busy
        run_burst(2046, 4, 1'b0, 1'b1);
        check_burst("wrap", 2046, 4);

        // Stalled consumer
        run_burst(30, 8, 1'b1, 1'b0);
        check_burst("stall", 30, 8);

        // Zero length
        mon_clear();
        ifc.start = 1'b1; ifc.base_addr = 11'd7; ifc.len = 12'd0;
        @(negedge CLK);
        chk("len0 c0 done", ifc.done, 0);
        chk("len0 c0 CEN", ifc.CEN, 1);
        @(posedge CLK); #1 ifc.start = 1'b0;
        @(negedge CLK);
        chk("len0 c1 done", ifc.done, 1);
        chk("len0 c1 busy", ifc.busy, 0);
        @(negedge CLK);
        chk("len0 c2 done", ifc.done, 0);
        chk("len0 c2 busy", ifc.busy, 0);
        chk("len0 reads", rd_q.size(), 0);
        chk("len0 done pulses", done_cnt, 1);

        // Full memory
        run_burst(0, 2048, 1'b0, 1'b0);
        check_burst("full", 0, 2048);

        // Reset mid-burst
        mon_clear();
        ifc.start = 1'b1; ifc.base_addr = 11'd20; ifc.len = 12'd10;
        @(posedge CLK); #1 ifc.start = 1'b0;
        cyc = 0;
        while (dat_q.size() < 3 && cyc < 100) begin
            @(posedge CLK); cyc++;
        end
        chk("rst wait 3 words", (dat_q.size() >= 3), 1);
        #1 RESET_N = 1'b0;
        #1;
        chk("rst CEN", ifc.CEN, 1);
        chk("rst out_valid", ifc.out_valid, 0);
        chk("rst busy", ifc.busy, 0);
        chk("rst out_data", ifc.out_data, 0);
        repeat (2) @(posedge CLK);
        #3 RESET_N = 1'b1;
        rd_before = rd_q.size();
        repeat (5) @(posedge CLK);
        #1;
        chk("rst no further reads", rd_q.size(), rd_before);
        chk("rst no done", done_cnt, 0);
        run_burst(0, 2, 1'b0, 1'b0);
        check_burst("after rst", 0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sram_stream_reader.md
SRAM_STREAM_READER -- requirements
Module: sram_stream_reader

Interface
REQ-001 Parameter: AW, 11, SRAM address width (2048 words).
REQ-002 Parameter: DW, 32, SRAM data width.
REQ-003 Port: CLK  input  1  single clock; all state updates on posedge CLK.
REQ-004 Port: RESET_N  input  1  asynchronous, active-low reset.
REQ-005 Port: start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-006 Port: base_addr  input  AW  first word address, sampled with start.
REQ-007 Port: len  input  AW+1  burst length in words, 0..2048, sampled with start.
REQ-008 Port: busy  output  1  high from the cycle after an accepted start until the cycle done is asserted.
REQ-009 Port: done  output  1  one-cycle pulse when a burst completes.
REQ-010 Port: CEN  output  1  SRAM chip enable, active-low.
REQ-011 Port: WEN  output  1  SRAM write enable, active-low; tied 1 (read-only master).
REQ-012 Port: A  output  AW  SRAM address.
REQ-013 Port: D  output  DW  SRAM write data; tied 0.
REQ-014 Port: Q  input  DW  SRAM read data, valid the cycle after a read is issued.
REQ-015 Port: out_valid  output  1  stream word available.
REQ-016 Port: out_ready  input  1  consumer accepts; transfer occurs when out_valid && out_ready.
REQ-017 Port: out_data  output  DW  stream word.
REQ-018 Port: out_last  output  1  high with the final word of a burst.

Function
REQ-019 FSM states: IDLE, READ, DRAIN.
- IDLE -> READ on start with len != 0.
- READ -> DRAIN when the last read is issued.
- DRAIN -> IDLE on the transfer of the out_last word; done pulses in that same cycle.
REQ-020 In IDLE, start with len == 0 shall issue no read and shall pulse done the following cycle; the FSM stays in IDLE.
REQ-021 Start while busy shall be ignored.
REQ-022 A read issue is one cycle with CEN=0, WEN=1 and A equal to the current address; CEN shall be 1 in every other cycle.
REQ-023 Issue rule: a read is issued only when the following holds, giving one word per cycle under continuous out_ready:
- words remaining > 0, and
- (buffer count + in-flight reads - pop this cycle) < 2.
REQ-024 In-flight read data (Q) shall be written into a 2-entry FIFO on the posedge ending the cycle after the issue.
REQ-025 out_valid = FIFO not empty; out_data and out_last come from the FIFO head.
REQ-026 Data shall be held stable while out_valid && !out_ready.
REQ-027 Address increments by 1 per issue, modulo 2^AW (2047 -> 0).
REQ-028 Issued words are counted with an (AW+1)-bit counter, so len=2048 reads every word exactly once.
REQ-029 out_last shall accompany exactly the len-th word of the burst; each word is emitted exactly once, in address order.
REQ-030 A simultaneous FIFO push and pop shall keep count unchanged and preserve order.
REQ-031 When idle, A shall equal 0.

Reset
REQ-032 On RESET_N=0, asynchronously:
- FSM -> IDLE.
- FIFO count, in-flight and counters cleared.
- CEN=1, A=0, busy=0, done=0, out_valid=0, out_last=0, out_data=0.
REQ-033 Reset mid-burst shall abandon the burst with no further SRAM accesses and no done pulse; operation resumes on the next start after RESET_N returns high.

Verification
REQ-034 Burst base=5, len=4, out_ready=1, SRAM preloaded mem[i]=i+100 -> CEN low for 4 consecutive cycles, A=5,6,7,8; out_data 105,106,107,108 on consecutive cycles; out_last with 108; done in the 108 transfer cycle.
REQ-035 base=2046, len=4 -> A=2046,2047,0,1; data in that order.
REQ-036 len=8, out_ready toggled 1,0,0,1,... -> never more than 2 words buffered-or-in-flight; no word lost or duplicated; out_data stable while stalled.
REQ-037 len=0 -> no CEN low cycle; done high exactly one cycle later; busy stays 0.
REQ-038 len=2048, base=0 -> 2048 reads covering every address once; out_last on word 2047 only.
REQ-039 RESET_N pulsed low after 3 of len=10 words -> CEN=1 and out_valid=0 immediately; no done; a new burst base=0, len=2 then completes normally.
